// File: rtl/mem_access_stage.sv
// MEM stage: issues sized loads/stores on a req/ack data bus, stalls the pipe while
// an access is outstanding, resolves branches and registers results into MEM/WB.
module mem_access_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] ALUResult_in,
  input  logic [DATA_W-1:0] RD2_in,
  input  logic [ADDR_W-1:0] Add2_in,
  input  logic [4:0]        Rd_in,
  input  logic [2:0]        Funct3_in,
  input  logic              zero_in,
  input  logic              RegWrite_in,
  input  logic              MemToReg_in,
  input  logic              MemWrite_in,
  input  logic              MemRead_in,
  input  logic              Branch_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              Stall_out,
  output logic              PCSrc_out,
  output logic [ADDR_W-1:0] BranchTarget_out,
  output logic [DATA_W-1:0] ReadData_out,
  output logic [DATA_W-1:0] ALUResult_out,
  output logic [4:0]        Rd_out,
  output logic              RegWrite_out,
  output logic              MemToReg_out,
  output logic              MisalignFault_out
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_t            state_q, state_d;
  logic              memReq_q, memReq_d;
  logic              memWe_q, memWe_d;
  logic [ADDR_W-1:0] memAddr_q, memAddr_d;
  logic [DATA_W-1:0] memWdata_q, memWdata_d;
  logic [3:0]        memBe_q, memBe_d;
  logic [1:0]        offset_q, offset_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [DATA_W-1:0] readData_q, readData_d;
  logic [DATA_W-1:0] aluResult_q, aluResult_d;
  logic [4:0]        rd_q, rd_d;
  logic              regWrite_q, regWrite_d;
  logic              memToReg_q, memToReg_d;
  logic              fault_q, fault_d;

  logic              memOp, misaligned, issue, fault, ackEdge;
  logic [1:0]        offset;
  logic [3:0]        beNext;
  logic [DATA_W-1:0] wdataNext, loadData;
  logic [7:0]        byteSel;
  logic [15:0]       halfSel;

  assign memOp   = MemRead_in | MemWrite_in;
  assign offset  = ALUResult_in[1:0];
  assign issue   = (state_q == IDLE) && memOp && !misaligned;
  assign fault   = (state_q == IDLE) && memOp && misaligned;
  assign ackEdge = (state_q == BUSY) && mem_ack;

  assign Stall_out        = issue || ((state_q == BUSY) && !mem_ack);
  assign PCSrc_out        = Branch_in & zero_in;
  assign BranchTarget_out = Add2_in;

  // Size decode: alignment check plus lane-placed byte enables and replicated store data.
  always_comb begin
    misaligned = 1'b0;
    beNext     = 4'b1111;
    wdataNext  = RD2_in;
    case (Funct3_in)
      F3_B, F3_BU: begin
        beNext    = 4'b0001 << offset;
        wdataNext = {4{RD2_in[7:0]}};
      end
      F3_H, F3_HU: begin
        misaligned = offset[0];
        beNext     = 4'b0011 << offset;
        wdataNext  = {2{RD2_in[15:0]}};
      end
      F3_W: misaligned = (offset != 2'b00);
      default: ;
    endcase
  end

  assign byteSel = mem_rdata[8*offset_q +: 8];
  assign halfSel = offset_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    case (funct3_q)
      F3_B:    loadData = {{24{byteSel[7]}}, byteSel};
      F3_BU:   loadData = {24'd0, byteSel};
      F3_H:    loadData = {{16{halfSel[15]}}, halfSel};
      F3_HU:   loadData = {16'd0, halfSel};
      default: loadData = mem_rdata;
    endcase
  end

  // Bus FSM and MEM/WB next state; bus outputs stay frozen for the whole BUSY period.
  always_comb begin
    state_d     = state_q;
    memReq_d    = memReq_q;
    memWe_d     = memWe_q;
    memAddr_d   = memAddr_q;
    memWdata_d  = memWdata_q;
    memBe_d     = memBe_q;
    offset_d    = offset_q;
    funct3_d    = funct3_q;
    readData_d  = readData_q;
    aluResult_d = aluResult_q;
    rd_d        = rd_q;
    regWrite_d  = 1'b0;
    memToReg_d  = 1'b0;
    fault_d     = fault;
    case (state_q)
      IDLE: if (issue) begin
        state_d    = BUSY;
        memReq_d   = 1'b1;
        memWe_d    = MemWrite_in;
        memAddr_d  = {ALUResult_in[ADDR_W-1:2], 2'b00};
        memWdata_d = wdataNext;
        memBe_d    = beNext;
        offset_d   = offset;
        funct3_d   = Funct3_in;
      end
      BUSY: if (mem_ack) begin
        state_d  = IDLE;
        memReq_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    if (!Stall_out && !fault) begin
      aluResult_d = ALUResult_in;
      rd_d        = Rd_in;
      regWrite_d  = RegWrite_in;
      memToReg_d  = MemToReg_in;
    end
    if (ackEdge) readData_d = loadData;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      memReq_q    <= 1'b0;
      memWe_q     <= 1'b0;
      memAddr_q   <= '0;
      memWdata_q  <= '0;
      memBe_q     <= '0;
      offset_q    <= '0;
      funct3_q    <= '0;
      readData_q  <= '0;
      aluResult_q <= '0;
      rd_q        <= '0;
      regWrite_q  <= 1'b0;
      memToReg_q  <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      memReq_q    <= memReq_d;
      memWe_q     <= memWe_d;
      memAddr_q   <= memAddr_d;
      memWdata_q  <= memWdata_d;
      memBe_q     <= memBe_d;
      offset_q    <= offset_d;
      funct3_q    <= funct3_d;
      readData_q  <= readData_d;
      aluResult_q <= aluResult_d;
      rd_q        <= rd_d;
      regWrite_q  <= regWrite_d;
      memToReg_q  <= memToReg_d;
      fault_q     <= fault_d;
    end
  end

  assign mem_req           = memReq_q;
  assign mem_we            = memWe_q;
  assign mem_addr          = memAddr_q;
  assign mem_wdata         = memWdata_q;
  assign mem_be            = memBe_q;
  assign ReadData_out      = readData_q;
  assign ALUResult_out     = aluResult_q;
  assign Rd_out            = rd_q;
  assign RegWrite_out      = regWrite_q;
  assign MemToReg_out      = memToReg_q;
  assign MisalignFault_out = fault_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: loads, stores, misalignment, branches and reset mid-access.
module tb_mem_access_stage;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] ALUResult_in, RD2_in, Add2_in, mem_rdata;
  logic [4:0]  Rd_in;
  logic [2:0]  Funct3_in;
  logic        zero_in, RegWrite_in, MemToReg_in, MemWrite_in, MemRead_in, Branch_in, mem_ack;
  logic        mem_req, mem_we, Stall_out, PCSrc_out, RegWrite_out, MemToReg_out, MisalignFault_out;
  logic [31:0] mem_addr, mem_wdata, BranchTarget_out, ReadData_out, ALUResult_out;
  logic [3:0]  mem_be;
  logic [4:0]  Rd_out;

  int testsRun = 0;
  int testsFailed = 0;

  mem_access_stage dut (
    .clock(clock), .reset_n(reset_n),
    .ALUResult_in(ALUResult_in), .RD2_in(RD2_in), .Add2_in(Add2_in), .Rd_in(Rd_in),
    .Funct3_in(Funct3_in), .zero_in(zero_in), .RegWrite_in(RegWrite_in),
    .MemToReg_in(MemToReg_in), .MemWrite_in(MemWrite_in), .MemRead_in(MemRead_in),
    .Branch_in(Branch_in), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .Stall_out(Stall_out), .PCSrc_out(PCSrc_out), .BranchTarget_out(BranchTarget_out),
    .ReadData_out(ReadData_out), .ALUResult_out(ALUResult_out), .Rd_out(Rd_out),
    .RegWrite_out(RegWrite_out), .MemToReg_out(MemToReg_out),
    .MisalignFault_out(MisalignFault_out)
  );

  always #5 clock = ~clock;

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic regW, input logic m2r,
                               input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [4:0] dest);
    MemRead_in   = rd;
    MemWrite_in  = wr;
    RegWrite_in  = regW;
    MemToReg_in  = m2r;
    Funct3_in    = f3;
    ALUResult_in = addr;
    RD2_in       = wdata;
    Rd_in        = dest;
    Branch_in    = 1'b0;
    zero_in      = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    Add2_in   = 32'h0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    #3;
    checkOutput("reset_mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("reset_regwrite", {31'd0, RegWrite_out}, 32'd0);
    checkOutput("reset_readdata", ReadData_out, 32'h0);
    checkOutput("reset_fault", {31'd0, MisalignFault_out}, 32'd0);
    checkOutput("reset_stall", {31'd0, Stall_out}, 32'd0);
    step; step;
    #3 reset_n = 1'b1;

    // Non-memory op: one-cycle latency, no stall
    step;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 32'h55, 32'h0, 5'd7);
    #1 checkOutput("alu_stall", {31'd0, Stall_out}, 32'd0);
    step;
    checkOutput("alu_result", ALUResult_out, 32'h55);
    checkOutput("alu_rd", {27'd0, Rd_out}, 32'd7);
    checkOutput("alu_regwrite", {31'd0, RegWrite_out}, 32'd1);

    // LW 0x100, ack one cycle after req
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 32'h100, 32'h0, 5'd5);
    #1 checkOutput("lw_stall_c0", {31'd0, Stall_out}, 32'd1);
    checkOutput("lw_req_c0", {31'd0, mem_req}, 32'd0);
    step;
    checkOutput("lw_req", {31'd0, mem_req}, 32'd1);
    checkOutput("lw_addr", mem_addr, 32'h100);
    checkOutput("lw_be", {28'd0, mem_be}, 32'hF);
    checkOutput("lw_we", {31'd0, mem_we}, 32'd0);
    checkOutput("lw_stall_c1", {31'd0, Stall_out}, 32'd1);
    checkOutput("lw_bubble", {31'd0, RegWrite_out}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    #1 checkOutput("lw_stall_ack", {31'd0, Stall_out}, 32'd0);
    step;
    mem_ack = 1'b0;
    checkOutput("lw_req_done", {31'd0, mem_req}, 32'd0);
    checkOutput("lw_data", ReadData_out, 32'hDEADBEEF);
    checkOutput("lw_regwrite", {31'd0, RegWrite_out}, 32'd1);
    checkOutput("lw_memtoreg", {31'd0, MemToReg_out}, 32'd1);
    checkOutput("lw_rd", {27'd0, Rd_out}, 32'd5);

    // LB 0x103 then back-to-back LBU of the same byte
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 3'b000, 32'h103, 32'h0, 5'd6);
    step;
    checkOutput("lb_be", {28'd0, mem_be}, 32'h8);
    checkOutput("lb_addr", mem_addr, 32'h100);
    mem_ack = 1'b1; mem_rdata = 32'h80FF0000;
    step;
    mem_ack = 1'b0;
    checkOutput("lb_data", ReadData_out, 32'hFFFFFF80);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 3'b100, 32'h103, 32'h0, 5'd6);
    #1 checkOutput("lbu_stall", {31'd0, Stall_out}, 32'd1);
    step;
    checkOutput("lbu_req", {31'd0, mem_req}, 32'd1);
    mem_ack = 1'b1;
    step;
    mem_ack = 1'b0;
    checkOutput("lbu_data", ReadData_out, 32'h00000080);

    // SH 0x202 with a three-cycle ack delay
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 32'h202, 32'h1234ABCD, 5'd0);
    step;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("sh_req_%0d", i), {31'd0, mem_req}, 32'd1);
      checkOutput($sformatf("sh_we_%0d", i), {31'd0, mem_we}, 32'd1);
      checkOutput($sformatf("sh_be_%0d", i), {28'd0, mem_be}, 32'hC);
      checkOutput($sformatf("sh_wdata_%0d", i), mem_wdata, 32'hABCDABCD);
      checkOutput($sformatf("sh_addr_%0d", i), mem_addr, 32'h200);
      checkOutput($sformatf("sh_regwrite_%0d", i), {31'd0, RegWrite_out}, 32'd0);
      if (i < 3) begin
        checkOutput($sformatf("sh_stall_%0d", i), {31'd0, Stall_out}, 32'd1);
        step;
      end
    end
    mem_ack = 1'b1;
    #1 checkOutput("sh_stall_ack", {31'd0, Stall_out}, 32'd0);
    step;
    mem_ack = 1'b0;
    checkOutput("sh_req_done", {31'd0, mem_req}, 32'd0);
    checkOutput("sh_regwrite_done", {31'd0, RegWrite_out}, 32'd0);

    // Misaligned LW 0x101
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 32'h101, 32'h0, 5'd9);
    #1 checkOutput("mis_stall", {31'd0, Stall_out}, 32'd0);
    step;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    checkOutput("mis_req", {31'd0, mem_req}, 32'd0);
    checkOutput("mis_fault", {31'd0, MisalignFault_out}, 32'd1);
    checkOutput("mis_regwrite", {31'd0, RegWrite_out}, 32'd0);
    step;
    checkOutput("mis_fault_clear", {31'd0, MisalignFault_out}, 32'd0);

    // Branch resolution
    Branch_in = 1'b1; zero_in = 1'b1; Add2_in = 32'h40;
    #1 checkOutput("br_taken", {31'd0, PCSrc_out}, 32'd1);
    checkOutput("br_target", BranchTarget_out, 32'h40);
    zero_in = 1'b0;
    #1 checkOutput("br_not_taken", {31'd0, PCSrc_out}, 32'd0);
    Branch_in = 1'b0;

    // Reset while BUSY, late ack ignored, then a normal LW
    step;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 32'h100, 32'h0, 5'd5);
    step;
    checkOutput("rst_busy_req", {31'd0, mem_req}, 32'd1);
    #2 reset_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    #1 checkOutput("rst_mid_req", {31'd0, mem_req}, 32'd0);
    checkOutput("rst_mid_addr", mem_addr, 32'h0);
    checkOutput("rst_mid_be", {28'd0, mem_be}, 32'h0);
    checkOutput("rst_mid_readdata", ReadData_out, 32'h0);
    checkOutput("rst_mid_alu", ALUResult_out, 32'h0);
    step;
    #3 reset_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'h11111111;
    step;
    mem_ack = 1'b0;
    checkOutput("late_ack_req", {31'd0, mem_req}, 32'd0);
    checkOutput("late_ack_data", ReadData_out, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 32'h104, 32'h0, 5'd3);
    step;
    checkOutput("post_rst_req", {31'd0, mem_req}, 32'd1);
    checkOutput("post_rst_addr", mem_addr, 32'h104);
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    step;
    mem_ack = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
    checkOutput("post_rst_data", ReadData_out, 32'hCAFEF00D);
    checkOutput("post_rst_regwrite", {31'd0, RegWrite_out}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the 5-stage RISC-V pipeline, directly downstream of the EX/MEM register; consumes its outputs.
- Runs loads and stores over a req/ack data-memory bus with byte/half/word sizing and sign/zero extension.
- Stalls upstream while a bus access is outstanding and resolves branches (Branch & zero).
- Registers results into the MEM/WB boundary for writeback.

Parameters:
- ADDR_W, 32, data address width.
- DATA_W, 32, data width (fixed at 32; the lane logic assumes 4 bytes).

Ports:
- clock  in  1  pipeline clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- ALUResult_in  in  32  effective address, or ALU result for non-memory ops.
- RD2_in  in  32  store data.
- Add2_in  in  32  branch target.
- Rd_in  in  5  destination register.
- Funct3_in  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- zero_in, RegWrite_in, MemToReg_in, MemWrite_in, MemRead_in, Branch_in  in  1 each  control from EX/MEM.
- mem_req  out  1  bus request.
- mem_we  out  1  1 = store.
- mem_addr  out  32  word-aligned address.
- mem_wdata  out  32  lane-replicated store data.
- mem_be  out  4  byte enables.
- mem_rdata  in  32  read data, valid when mem_ack = 1.
- mem_ack  in  1  access complete.
- Stall_out  out  1  hold EX/MEM and all earlier stages.
- PCSrc_out  out  1  branch taken.
- BranchTarget_out  out  32  branch target.
- ReadData_out  out  32  extended load data (MEM/WB).
- ALUResult_out  out  32  MEM/WB.
- Rd_out  out  5  MEM/WB.
- RegWrite_out  out  1  MEM/WB.
- MemToReg_out  out  1  MEM/WB.
- MisalignFault_out  out  1  one-cycle fault pulse.

Behaviour:
- Reset (async, reset_n = 0):
  - All registered outputs clear to 0, including mem_req, mem_we, mem_addr, mem_wdata, mem_be, ReadData_out, ALUResult_out, Rd_out, RegWrite_out, MemToReg_out and MisalignFault_out.
  - FSM goes to IDLE.
  - Reset mid-access drops mem_req immediately and abandons the access; a late mem_ack is ignored.
- Definitions:
  - mem_op = MemRead_in | MemWrite_in. If both are high, the op is treated as a store.
  - misaligned = (H/HU and addr[0]) or (W and addr[1:0] != 0).
- FSM, 2 states:
  - IDLE: if mem_op & !misaligned, register mem_req = 1, mem_we, mem_addr = {addr[31:2], 00}, mem_be, mem_wdata, then go to BUSY.
  - BUSY: hold every bus output stable until mem_ack = 1. On the ack edge, clear mem_req and return to IDLE.
- Byte enables and store data:
  - B: be = 0001 << addr[1:0], wdata = {4{RD2[7:0]}}.
  - H: be = 0011 << addr[1:0], wdata = {2{RD2[15:0]}}.
  - W: be = 1111, wdata = RD2.
  - Loads also drive be per size; the load mask is informational for the bus.
- Load extraction: select the byte or half from mem_rdata by the registered addr[1:0]. B/H sign-extend; BU/HU zero-extend; W passes through.
- Stall_out (combinational) = (IDLE & mem_op & !misaligned) | (BUSY & !mem_ack).
  - A single-cycle-ack bus therefore costs 1 stall cycle.
  - Upstream holds inputs stable while Stall_out = 1.
- MEM/WB update, every clock edge:
  - While Stall_out = 1: insert a bubble (RegWrite_out = 0, MemToReg_out = 0); all other MEM/WB fields are don't-care.
  - Otherwise: ALUResult_out, Rd_out, MemToReg_out and RegWrite_out load from the inputs. ReadData_out loads the extended data on the ack edge; otherwise it holds.
  - Non-memory ops: 1-cycle latency, no stall.
  - Stores: RegWrite_out follows RegWrite_in (expected 0).
- Misaligned op:
  - No bus access and no stall.
  - MEM/WB receives a bubble (RegWrite_out = 0).
  - MisalignFault_out = 1 for exactly 1 cycle.
- Branch resolution (combinational):
  - PCSrc_out = Branch_in & zero_in.
  - BranchTarget_out = Add2_in.
  - Independent of the FSM; a branch never coincides with a mem_op.
- Back-to-back memory ops: after ack the FSM is in IDLE, and the next op issues on the following edge with no dead cycle beyond its own stall.
- mem_ack while IDLE: ignored.

Test Plan:
- LW, addr 0x100, ack 1 cycle after req, rdata 0xDEADBEEF → mem_addr = 0x100, be = 1111, Stall_out high 2 cycles, then RegWrite_out = 1, ReadData_out = 0xDEADBEEF.
- LB, addr 0x103, rdata 0x80FF_0000 → be = 1000; extracts byte 0x80 → ReadData_out = 0xFFFFFF80. Same access as LBU → 0x00000080.
- SH, addr 0x202, RD2 = 0x1234ABCD, ack delayed 3 cycles → mem_we = 1, be = 1100, wdata = 0xABCDABCD, all bus outputs stable 4 cycles, RegWrite_out = 0 throughout.
- LW, addr 0x101 → no mem_req, Stall_out = 0, MisalignFault_out pulse 1 cycle, RegWrite_out = 0.
- Branch_in = 1, zero_in = 1, Add2_in = 0x40 → PCSrc_out = 1, BranchTarget_out = 0x40 in the same cycle. With zero_in = 0 → PCSrc_out = 0.
- Assert reset_n = 0 in BUSY before ack → mem_req = 0 immediately, all outputs 0; ack after release ignored; the next LW issues normally.
